// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: bridges the inst/data SRAM-like ports onto one AXI3 master with single-beat transfers.
module sram_axi_arbiter #(
    parameter int DATA_PRIO = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        inst_sram_req,
    input  logic        inst_sram_wr,
    input  logic [1:0]  inst_sram_size,
    input  logic [3:0]  inst_sram_wstrb,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_addr_ok,
    output logic        inst_sram_data_ok,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_req,
    input  logic        data_sram_wr,
    input  logic [1:0]  data_sram_size,
    input  logic [3:0]  data_sram_wstrb,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_addr_ok,
    output logic        data_sram_data_ok,
    output logic [31:0] data_sram_rdata,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [1:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_B} w_state_t;

    r_state_t    r_state, r_next;
    w_state_t    w_state, w_next;
    logic        r_id;
    logic [31:0] ar_addr, aw_addr, w_data_q;
    logic [2:0]  ar_size, aw_size;
    logic [3:0]  w_strb_q;
    logic        aw_done, w_done;
    logic        data_rd_cand, grant_inst, grant_data, w_accept, r_hit;

    assign data_rd_cand = data_sram_req & ~data_sram_wr & (w_state == W_IDLE);
    assign grant_data   = (r_state == R_IDLE) & data_rd_cand & ((DATA_PRIO != 0) | ~inst_sram_req);
    assign grant_inst   = (r_state == R_IDLE) & inst_sram_req & ((DATA_PRIO == 0) | ~data_rd_cand);
    // a write may start while an inst read is in flight, never alongside a data read
    assign w_accept     = (w_state == W_IDLE) & data_sram_req & data_sram_wr & ((r_state == R_IDLE) | ~r_id);
    assign r_hit        = (r_state == R_R) & rvalid & (rid == {3'b0, r_id});

    assign inst_sram_addr_ok = grant_inst;
    assign data_sram_addr_ok = grant_data | w_accept;
    assign inst_sram_data_ok = r_hit & ~r_id;
    assign data_sram_data_ok = (r_hit & r_id) | ((w_state == W_B) & bvalid);
    assign inst_sram_rdata   = (r_hit & ~r_id) ? rdata : 32'd0;
    assign data_sram_rdata   = (r_hit & r_id) ? rdata : 32'd0;

    assign arid    = {3'b0, r_id};
    assign araddr  = ar_addr;
    assign arsize  = ar_size;
    assign arvalid = r_state == R_AR;
    assign rready  = r_state == R_R;
    assign awaddr  = aw_addr;
    assign awsize  = aw_size;
    assign awvalid = (w_state == W_SEND) & ~aw_done;
    assign wdata   = w_data_q;
    assign wstrb   = w_strb_q;
    assign wvalid  = (w_state == W_SEND) & ~w_done;
    assign bready  = w_state == W_B;

    assign arlen   = 8'd0;
    assign arburst = 2'b01;
    assign arlock  = 2'd0;
    assign arcache = 4'd0;
    assign arprot  = 3'd0;
    assign awid    = 4'd1;
    assign awlen   = 8'd0;
    assign awburst = 2'b01;
    assign awlock  = 2'd0;
    assign awcache = 4'd0;
    assign awprot  = 3'd0;
    assign wid     = 4'd1;
    assign wlast   = 1'b1;

    always_comb begin
        r_next = r_state;
        w_next = w_state;
        r_next = (r_state == R_IDLE) ? ((grant_inst | grant_data) ? R_AR : R_IDLE) :
                 (r_state == R_AR)   ? (arready ? R_R : R_AR) :
                                       (r_hit ? R_IDLE : R_R);
        w_next = (w_state == W_IDLE) ? (w_accept ? W_SEND : W_IDLE) :
                 (w_state == W_SEND) ? (((aw_done | awready) & (w_done | wready)) ? W_B : W_SEND) :
                                       (bvalid ? W_IDLE : W_B);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= R_IDLE;
            w_state  <= W_IDLE;
            r_id     <= 1'b0;
            ar_addr  <= 32'd0;
            ar_size  <= 3'd0;
            aw_addr  <= 32'd0;
            aw_size  <= 3'd0;
            w_strb_q <= 4'd0;
            w_data_q <= 32'd0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            r_state <= r_next;
            w_state <= w_next;
            if (grant_inst | grant_data) begin
                r_id    <= grant_data;
                ar_addr <= grant_data ? data_sram_addr : inst_sram_addr;
                ar_size <= {1'b0, grant_data ? data_sram_size : inst_sram_size};
            end
            if (w_accept) begin
                aw_addr  <= data_sram_addr;
                aw_size  <= {1'b0, data_sram_size};
                w_strb_q <= data_sram_wstrb;
                w_data_q <= data_sram_wdata;
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end else begin
                if (awvalid & awready) aw_done <= 1'b1;
                if (wvalid & wready) w_done <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sram_axi_arbiter.sv
// tb_sram_axi_arbiter: directed checks of the SRAM-like to AXI bridge with hand-computed expectations.
module tb_sram_axi_arbiter;
    logic        clk = 0;
    logic        resetn;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        data_sram_req, data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok, data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic [3:0]  arid, awid, wid, rid, arcache, awcache, wstrb;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, awsize, arprot, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bid, bresp;
    logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_axi_arbiter dut (
        .clk(clk), .resetn(resetn),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
        .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr), .data_sram_size(data_sram_size),
        .data_sram_wstrb(data_sram_wstrb), .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
        .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
        .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // advance one cycle; inputs change just after the edge, checks follow a further #1
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn = 0;
        {inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_wstrb, inst_sram_addr, inst_sram_wdata} = '0;
        {data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata} = '0;
        {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
        inst_sram_size = 2'd2;
        data_sram_size = 2'd2;
        step(); step();
        #1;
        check("rst_arvalid", {31'd0, arvalid}, 0);
        check("rst_rready", {31'd0, rready}, 0);
        check("rst_aw_w_b", {29'd0, awvalid, wvalid, bready}, 0);
        check("rst_ok", {28'd0, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 0);
        check("const_wlast_awid", {27'd0, wlast, awid}, 32'h11);
        resetn = 1;

        // inst read alone
        step();
        inst_sram_req = 1; inst_sram_addr = 32'h1C000000;
        #1 check("t1_inst_addr_ok", {31'd0, inst_sram_addr_ok}, 1);
        check("t1_data_addr_ok", {31'd0, data_sram_addr_ok}, 0);
        step();
        inst_sram_req = 0; arready = 1;
        #1 check("t1_arvalid", {31'd0, arvalid}, 1);
        check("t1_araddr", araddr, 32'h1C000000);
        check("t1_arid_size", {25'd0, arid, arsize}, {25'd0, 4'd0, 3'd2});
        step();
        arready = 0; rvalid = 1; rid = 0; rdata = 32'h02800C0C;
        #1 check("t1_data_ok", {31'd0, inst_sram_data_ok}, 1);
        check("t1_rdata", inst_sram_rdata, 32'h02800C0C);
        check("t1_no_data_ok", {31'd0, data_sram_data_ok}, 0);
        step();
        rvalid = 0;
        #1 check("t1_ok_pulse", {31'd0, inst_sram_data_ok}, 0);

        // simultaneous inst and data reads, data has priority
        inst_sram_req = 1; inst_sram_addr = 32'h1C000004;
        data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h200;
        #1 check("t2_data_grant", {30'd0, data_sram_addr_ok, inst_sram_addr_ok}, 2'b10);
        step();
        data_sram_req = 0; arready = 1;
        #1 check("t2_ar_data", {27'd0, arvalid, arid}, {27'd0, 1'b1, 4'd1});
        check("t2_araddr", araddr, 32'h200);
        check("t2_inst_wait1", {31'd0, inst_sram_addr_ok}, 0);
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'hAAAA5555;
        #1 check("t2_data_ok", {30'd0, data_sram_data_ok, inst_sram_data_ok}, 2'b10);
        check("t2_data_rdata", data_sram_rdata, 32'hAAAA5555);
        check("t2_inst_wait2", {31'd0, inst_sram_addr_ok}, 0);
        step();
        rvalid = 0;
        #1 check("t2_inst_grant", {31'd0, inst_sram_addr_ok}, 1);
        step();
        inst_sram_req = 0; arready = 1;
        #1 check("t2_ar_inst", {27'd0, arvalid, arid}, {27'd0, 1'b1, 4'd0});
        check("t2_araddr_inst", araddr, 32'h1C000004);
        step();
        arready = 0; rvalid = 1; rid = 0; rdata = 32'h11112222;
        #1 check("t2_inst_ok", {30'd0, data_sram_data_ok, inst_sram_data_ok}, 2'b01);
        step();
        rvalid = 0;

        // store then load, awready delayed
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h100;
        data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h12345678;
        #1 check("t3_w_addr_ok", {31'd0, data_sram_addr_ok}, 1);
        step();
        data_sram_wr = 0; data_sram_addr = 32'h104; wready = 1;
        #1 check("t3_aw_w_valid", {30'd0, awvalid, wvalid}, 2'b11);
        check("t3_awaddr", awaddr, 32'h100);
        check("t3_wdata", wdata, 32'h12345678);
        check("t3_wstrb_size", {25'd0, wstrb, awsize}, {25'd0, 4'b0011, 3'd2});
        check("t3_load_blocked1", {31'd0, data_sram_addr_ok}, 0);
        step();
        #1 check("t3_w_dropped", {30'd0, awvalid, wvalid}, 2'b10);
        step();
        #1 check("t3_aw_hold3", {31'd0, awvalid}, 1);
        step();
        awready = 1;
        #1 check("t3_aw_hold4", {31'd0, awvalid}, 1);
        check("t3_load_blocked2", {31'd0, data_sram_addr_ok}, 0);
        step();
        awready = 0; wready = 0; bvalid = 1;
        #1 check("t3_b_phase", {29'd0, awvalid, wvalid, bready}, 3'b001);
        check("t3_w_data_ok", {31'd0, data_sram_data_ok}, 1);
        check("t3_load_blocked3", {31'd0, data_sram_addr_ok}, 0);
        step();
        bvalid = 0;
        #1 check("t3_load_grant", {31'd0, data_sram_addr_ok}, 1);
        step();
        data_sram_req = 0; arready = 1;
        #1 check("t3_load_ar", araddr, 32'h104);
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h0000ABCD;
        #1 check("t3_load_ok", data_sram_rdata, 32'h0000ABCD);
        step();
        rvalid = 0;

        // inst read overlapping a store in W_B
        data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h300; data_sram_wdata = 32'h5A5A5A5A;
        #1 check("t4_w_addr_ok", {31'd0, data_sram_addr_ok}, 1);
        step();
        data_sram_req = 0; awready = 1; wready = 1;
        #1 check("t4_aw_w", {30'd0, awvalid, wvalid}, 2'b11);
        step();
        awready = 0; wready = 0; inst_sram_req = 1; inst_sram_addr = 32'h1C000010;
        #1 check("t4_bready", {31'd0, bready}, 1);
        check("t4_inst_grant", {31'd0, inst_sram_addr_ok}, 1);
        step();
        inst_sram_req = 0; arready = 1; bvalid = 1;
        #1 check("t4_b_ok", {30'd0, data_sram_data_ok, inst_sram_data_ok}, 2'b10);
        check("t4_arvalid", {31'd0, arvalid}, 1);
        step();
        arready = 0; bvalid = 0; rvalid = 1; rid = 0; rdata = 32'hDEADBEEF;
        #1 check("t4_r_ok", {30'd0, data_sram_data_ok, inst_sram_data_ok}, 2'b01);
        check("t4_inst_rdata", inst_sram_rdata, 32'hDEADBEEF);
        check("t4_no_cross", data_sram_rdata, 32'd0);
        step();
        rvalid = 0;

        // wrong rid is ignored
        inst_sram_req = 1; inst_sram_addr = 32'h1C000020;
        step();
        inst_sram_req = 0; arready = 1;
        step();
        arready = 0; rvalid = 1; rid = 1; rdata = 32'h99999999;
        #1 check("t5_no_ok", {30'd0, data_sram_data_ok, inst_sram_data_ok}, 2'b00);
        step();
        rvalid = 0;
        #1 check("t5_stay_rr", {31'd0, rready}, 1);
        step();
        rvalid = 1; rid = 0; rdata = 32'h77777777;
        #1 check("t5_match_ok", {31'd0, inst_sram_data_ok}, 1);
        step();
        rvalid = 0;

        // reset while in R_AR
        inst_sram_req = 1; inst_sram_addr = 32'h1C000030;
        step();
        inst_sram_req = 0;
        #1 check("t6_in_ar", {31'd0, arvalid}, 1);
        resetn = 0;
        step();
        resetn = 1;
        #1 check("t6_arvalid", {31'd0, arvalid}, 0);
        check("t6_rready", {31'd0, rready}, 0);
        check("t6_oks", {28'd0, inst_sram_addr_ok, inst_sram_data_ok, data_sram_addr_ok, data_sram_data_ok}, 0);
        inst_sram_req = 1;
        #1 check("t6_idle_grant", {31'd0, inst_sram_addr_ok}, 1);
        step();
        inst_sram_req = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_axi_arbiter.md
# sram_axi_arbiter

Shares one AXI3 master port between the instruction and data SRAM-like request interfaces of the CPU core. It converts req/addr_ok/data_ok transactions into single-beat AXI reads and writes, and arbitrates the read channel between the fetch and memory stages. Ordering is enforced so that each SRAM-like port receives its data_ok responses in request order. It sits between the core's inst/data SRAM-like ports and the AXI interconnect.

## Interface
Parameters:
- DATA_PRIO, default 1: when 1, a data read wins read-channel arbitration over an inst read in the same cycle; when 0, inst wins.

Ports (grouped buses list widths in field order):
- clk  in  1  clock
- resetn  in  1  reset, synchronous, active-low
- inst_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  fetch request; wr, wstrb and wdata are ignored, so every inst request is a read
- inst_sram_{addr_ok,data_ok,rdata}  out  1/1/32  fetch request accept, response strobe and read data
- data_sram_{req,wr,size,wstrb,addr,wdata}  in  1/1/2/4/32/32  load/store request
- data_sram_{addr_ok,data_ok,rdata}  out  1/1/32  load/store request accept, response strobe and read data
- {arid,araddr,arsize,arvalid}  out  4/32/3/1  AXI read address channel
- arready  in  1  AXI read address accept
- {rid,rdata,rvalid}  in  4/32/1  AXI read data channel; rresp and rlast are ignored
- rready  out  1  AXI read data accept
- {awaddr,awsize,awvalid}  out  32/3/1  AXI write address channel
- awready  in  1  AXI write address accept
- {wdata,wstrb,wvalid}  out  32/4/1  AXI write data channel
- wready  in  1  AXI write data accept
- bvalid  in  1  AXI write response valid
- bready  out  1  AXI write response accept
- Constant outputs: arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0, awid=4'd1, awlen=0, awburst=2'b01, awlock=0, awcache=0, awprot=0, wid=4'd1, wlast=1

## Operation
Read FSM: R_IDLE, R_AR, R_R. At most one read is outstanding in total.
- R_IDLE: grant one read candidate.
  - Inst candidate: inst_sram_req.
  - Data candidate: data_sram_req & ~data_sram_wr & write FSM in W_IDLE.
  - DATA_PRIO resolves a conflict.
  - The granted port sees addr_ok=1 in the same cycle.
  - Latch addr, arsize={1'b0,size} and arid (0=inst, 1=data), then go to R_AR.
- R_AR: arvalid=1, with all AR fields held stable; on arready go to R_R.
- R_R: rready=1. When rvalid and rid matches the latched id:
  - pulse data_ok on the owning port for that cycle;
  - pass rdata through combinationally to that port's rdata;
  - go to R_IDLE.
  - rvalid with a non-matching rid is not accepted (rready stays 1; the beat is ignored, which the interconnect never produces).

Write FSM: W_IDLE, W_SEND, W_B.
- W_IDLE: accept a data write when data_sram_req & data_sram_wr and the read FSM is not holding a data read (it is in R_IDLE or serving inst).
  - In R_IDLE the read grant is evaluated on reads only, so a data write and an inst read may both be accepted in the same cycle.
  - addr_ok=1 in the same cycle.
  - Latch addr, awsize={1'b0,size}, wstrb and wdata; clear aw_done and w_done; go to W_SEND.
- W_SEND: awvalid=~aw_done and wvalid=~w_done, each dropped after its own handshake. The two channels complete in either order or together. Go to W_B once both are done, including when both complete in the same cycle.
- W_B: bready=1. On bvalid, pulse data_sram_data_ok and go to W_IDLE.

Hazard and ordering rules:
- Data reads and data writes are mutually exclusive in flight, so data_ok order is preserved and a read never overtakes an older store (RAW).
- Inst reads may overlap an outstanding write.
- addr_ok is never asserted without the corresponding req. A port keeps req high until it sees addr_ok.

## Timing
- Reset values (cycle after resetn=0 is sampled): both FSMs idle; arvalid=awvalid=wvalid=0; rready=bready=0; both addr_ok=0 and both data_ok=0; latched registers cleared. Reset mid-transaction returns to idle immediately. The interconnect shares resetn.
- addr_ok is combinational with req in the idle state.
- arvalid is first asserted in the cycle after addr_ok. awvalid and wvalid are likewise first asserted in the cycle after addr_ok.
- Minimum read latency: req/addr_ok at T, arvalid&arready at T+1, rvalid at T+2, data_ok at T+2.
- Minimum write latency: addr_ok at T, aw and w handshakes at T+1, bvalid at T+2, data_ok at T+2.
- The read FSM returns to R_IDLE in the data_ok cycle, so a new grant can occur the cycle after.
- data_ok is a single-cycle pulse, and rdata is valid only in that cycle.

## Test plan
- Inst read only: inst req, addr 0x1C000000, arready=1, rvalid one cycle later with rid=0 and rdata 0x02800C0C -> addr_ok at T, arvalid at T+1 with arid=0 and arsize=2, inst_sram_data_ok at T+2 with rdata 0x02800C0C.
- Simultaneous inst and data reads with DATA_PRIO=1 -> data read is granted first with arid=1; inst addr_ok stays 0 until the cycle after the data data_ok; inst is then granted.
- Store then load, data write addr 0x100 with wstrb 4'b0011 and awready delayed 3 cycles, wready=1 -> wvalid drops after 1 cycle; awvalid holds 4 cycles; the load's addr_ok stays 0 until the cycle after bvalid&bready.
- Inst read overlapping a store: write in W_B, inst req -> inst addr_ok is granted; both data_ok pulses appear on their own ports; no cross-delivery of rdata.
- Wrong rid: rvalid with rid=1 while an inst read is outstanding -> no data_ok on either port; FSM stays in R_R.
- Reset mid-read: resetn=0 in R_AR -> the next cycle has arvalid=0, the FSM in R_IDLE, and all addr_ok/data_ok=0.
